vga_raster_out: RTL and testbench
=================================

Name: vga_raster_out

Overview:
- Display end of the pixel-write interface driven by the drawing FSM.
- Accepts (x, y, color, writeEn) pixel writes into a 320x240x3-bit dual-port framebuffer.
- Scans the framebuffer out as 640x480@60 VGA with 2x pixel doubling, and generates the HS/VS/blank timing for the DAC.
- Returns the vertical-sync signal that the drawing FSM uses to start each frame redraw.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, HS pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VS pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- BG_COLOR, 3'b000, clear colour (used only with FB_CLEAR_EN)

Ports:
- clk  in  1  50 MHz system clock
- iReset  in  1  synchronous active-high reset
- x  in  9  write column, 0..319
- y  in  8  write row, 0..239
- color  in  3  {R,G,B} write colour
- writeEn  in  1  write strobe, one pixel per clk
- oVSync  out  1  copy of VGA_VS, returned to the drawing FSM
- oBusy  out  1  framebuffer clear in progress (FB_CLEAR_EN only, else 0)
- VGA_R, VGA_G, VGA_B  out  8 each  colour channels
- VGA_HS, VGA_VS  out  1 each  active-low syncs
- VGA_BLANK_N  out  1  low outside the visible area
- VGA_SYNC_N  out  1  tied 0
- VGA_CLK  out  1  25 MHz pixel clock (the pix_en phase)

Behaviour:
- Reset: iReset is synchronous, active-high; clock is clk.
- Reset values:
  - hCount=0, vCount=0, pix_en=0
  - VGA_HS=1, VGA_VS=1, oVSync=1, VGA_BLANK_N=0
  - RGB=0, oBusy=0
  - Framebuffer contents are not reset.
- Pixel tick: pix_en toggles every clk. All counters and outputs advance only on clk edges where pix_en=1, giving 1 pixel per 2 clk.
- Counters:
  - hCount runs 0..H_total-1 (800), then wraps to 0 and increments vCount.
  - vCount runs 0..V_total-1 (525), then wraps to 0.
- Timing at counter value c:
  - HS low for H_VIS+H_FP <= hCount < H_VIS+H_FP+H_SYNC (656..751).
  - VS low for 490 <= vCount < 492.
  - Visible when hCount<640 and vCount<480.
- Read path, pipelined over 2 ticks:
  - Tick 1 registers addr = (vCount>>1)*320 + (hCount>>1), computed as (y<<8)+(y<<6)+x with no multiplier, plus sync/visible flags.
  - Tick 2 registers RAM data and the delayed flags onto outputs.
  - Data and syncs are delayed identically, so outputs at tick n reflect counters at tick n-2.
- Colour expansion: each colour bit drives its 8-bit channel to 8'hFF when 1, 8'h00 when 0. RGB is forced to 0 when not visible.
- Write port:
  - Written on the clk edge with writeEn=1, independent of pix_en.
  - Address is (y<<8)+(y<<6)+x.
  - Writes with x>=320 or y>=240 are dropped (no aliasing).
  - No stall. Simultaneous read/write of the same address returns either old or new data; both are acceptable.
- oVSync equals VGA_VS exactly: one falling edge per frame, low for 2 lines = 3200 clk.
- Reset mid-frame: counters return to 0 on the next edge. Outputs take their reset values for at least 2 ticks before valid pixels appear.

Optional Feature:
- Macro: FB_CLEAR_EN.
- Defined:
  - After iReset falls, an internal counter sweeps addresses 0..76799, writing BG_COLOR one per clk.
  - oBusy=1 for exactly 76800 clk.
  - External writes are ignored while oBusy=1.
  - Scan-out runs throughout.
  - Reset during a clear restarts the clear.
- Undefined: no clear logic, oBusy tied 0, framebuffer powers up with undefined contents.

Test Plan:
- Sync timing: after reset, measure VGA_HS -> period 1600 clk, low 192 clk. Measure VGA_VS -> period 840000 clk, low 3200 clk. oVSync identical to VGA_VS.
- Pixel write/doubling: write (x=5, y=3, color=3'b100) -> at counters h=10,11 and v=6,7: VGA_R=8'hFF, VGA_G=VGA_B=0. Neighbours h=9 and h=12 show the prior contents.
- Out-of-range drop: pre-write (0,1)=3'b010, then write x=320,y=0,color=3'b111 -> (0,1) still displays green only. Repeat with y=240 -> no change anywhere.
- Blanking: any stored colour, hCount 640..799 or vCount 480..524 -> VGA_BLANK_N=0 and RGB=0 at the aligned output tick.
- Back-to-back writes: 320 consecutive writeEn cycles filling row 0 with 3'b011 -> line 0 and line 1 show G=B=8'hFF across the visible width. Scan-out timing is undisturbed.
- FB_CLEAR_EN, BG_COLOR=3'b001: oBusy high 76800 clk after reset; a write issued at clk 100 of the clear is ignored. Whole frame then shows B=8'hFF. Reset at clk 40000 -> oBusy stays high for a fresh 76800 clk.

Source files
------------

// File: rtl/vga_raster_out.sv
// vga_raster_out
//   Display end of the pixel-write path. The drawing FSM writes 3-bit pixels
//   into a 320x240 dual-port framebuffer. The framebuffer is scanned out as
//   640x480@60 VGA, with every stored pixel doubled horizontally and
//   vertically. HS/VS/blank are generated for the DAC, and VS is returned to
//   the drawing FSM as its frame-start reference.
//
//   Optional build macro: FB_CLEAR_EN. When it is defined, every reset is
//   followed by a sweep that fills the framebuffer with BG_COLOR, one word
//   per clk. oBusy is high during the sweep and external writes are ignored.
//   When it is not defined, oBusy is tied low and the framebuffer holds
//   whatever it powered up with.
//
// Ports
//   clk          50 MHz system clock
//   iReset       synchronous, active-high reset
//   x, y         write column (0..319) and row (0..239)
//   color        {R,G,B} write colour
//   writeEn      write strobe, one pixel per clk, independent of the pixel tick
//   oVSync       copy of VGA_VS
//   oBusy        framebuffer clear in progress (FB_CLEAR_EN only)
//   VGA_R/G/B    8-bit colour channels, each driven 8'hFF or 8'h00
//   VGA_HS/VS    active-low syncs
//   VGA_BLANK_N  low outside the visible area
//   VGA_SYNC_N   tied low
//   VGA_CLK      25 MHz pixel clock (the pix_en phase)
module vga_raster_out #(
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic [2:0]  BG_COLOR = 3'b000
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic [8:0] x,
  input  logic [7:0] y,
  input  logic [2:0] color,
  input  logic       writeEn,
  output logic       oVSync,
  output logic       oBusy,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK
);

  localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned FB_W     = 320;
  localparam int unsigned FB_H     = 240;
  localparam int unsigned FB_DEPTH = FB_W * FB_H;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  // row*320 + col, built from shifts so no multiplier is inferred
  function automatic logic [16:0] fb_addr(input logic [7:0] row, input logic [8:0] col);
    return {1'b0, row, 8'b0} + {3'b0, row, 6'b0} + {8'b0, col};
  endfunction

  // ---------------------------------------------------------------------------
  // Pixel tick and raster counters
  // ---------------------------------------------------------------------------
  logic       pix_en;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;

  always_ff @(posedge clk) begin
    if (iReset) begin
      pix_en <= 1'b0;
      h_cnt  <= '0;
      v_cnt  <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline, stage 1: address and timing flags from the counters
  // ---------------------------------------------------------------------------
  logic        vis_c;
  logic        hs_c;
  logic        vs_c;
  logic [16:0] rd_addr_c;

  always_comb begin
    vis_c     = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    hs_c      = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vs_c      = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    // Outside the visible area v_cnt>>1 can pass the last row, so the address
    // is parked at 0 to keep every read inside the array.
    rd_addr_c = vis_c ? fb_addr(v_cnt[8:1], h_cnt[9:1]) : '0;
  end

  logic [16:0] rd_addr_q;
  logic        vis_q;
  logic        hs_q;
  logic        vs_q;

  always_ff @(posedge clk) begin
    if (iReset) begin
      rd_addr_q <= '0;
      vis_q     <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else if (pix_en) begin
      rd_addr_q <= rd_addr_c;
      vis_q     <= vis_c;
      hs_q      <= hs_c;
      vs_q      <= vs_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Framebuffer: one write port, one registered read port
  // ---------------------------------------------------------------------------
  logic [2:0]  mem [FB_DEPTH];
  logic [2:0]  rd_data;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [2:0]  wr_data;
  logic        ext_ok;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read register carries no reset so it maps onto the RAM output
  // register. Its contents are masked by blank_n_q until valid data arrives.
  always_ff @(posedge clk) begin
    if (pix_en) begin
      rd_data <= mem[rd_addr_q];
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline, stage 2: delayed flags aligned with RAM data
  // ---------------------------------------------------------------------------
  logic blank_n_q;
  logic hs_o;
  logic vs_o;

  always_ff @(posedge clk) begin
    if (iReset) begin
      blank_n_q <= 1'b0;
      hs_o      <= 1'b1;
      vs_o      <= 1'b1;
    end else if (pix_en) begin
      blank_n_q <= vis_q;
      hs_o      <= hs_q;
      vs_o      <= vs_q;
    end
  end

  assign VGA_R       = blank_n_q ? {8{rd_data[2]}} : 8'h00;
  assign VGA_G       = blank_n_q ? {8{rd_data[1]}} : 8'h00;
  assign VGA_B       = blank_n_q ? {8{rd_data[0]}} : 8'h00;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_HS      = hs_o;
  assign VGA_VS      = vs_o;
  assign oVSync      = vs_o;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = pix_en;

  // ---------------------------------------------------------------------------
  // Write port and optional clear sweep
  // ---------------------------------------------------------------------------
`ifdef FB_CLEAR_EN
  typedef enum logic [1:0] {CLR_IDLE, CLR_START, CLR_RUN} clr_state_t;

  clr_state_t  clr_state;
  clr_state_t  clr_state_nx;
  logic [16:0] clr_addr;

  always_ff @(posedge clk) begin
    if (iReset) begin
      clr_state <= CLR_START;
      clr_addr  <= '0;
    end else begin
      clr_state <= clr_state_nx;
      clr_addr  <= (clr_state == CLR_RUN) ? clr_addr + 17'd1 : '0;
    end
  end

  always_comb begin
    clr_state_nx = clr_state;
    case (clr_state)
      CLR_START: clr_state_nx = CLR_RUN;
      CLR_RUN:   if (clr_addr == 17'(FB_DEPTH - 1)) clr_state_nx = CLR_IDLE;
      default:   clr_state_nx = CLR_IDLE;
    endcase
  end

  assign oBusy = (clr_state == CLR_RUN);
`else
  logic [2:0] unused_bg;
  assign unused_bg = BG_COLOR;
  assign oBusy     = 1'b0;
`endif

  always_comb begin
    ext_ok  = writeEn && (x < 9'(FB_W)) && (y < 8'(FB_H));
    wr_en   = 1'b0;
    wr_addr = fb_addr(y, x);
    wr_data = color;
`ifdef FB_CLEAR_EN
    if (clr_state == CLR_RUN) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = BG_COLOR;
    end else if (clr_state == CLR_IDLE) begin
      wr_en = ext_ok;
    end
`else
    wr_en = ext_ok;
`endif
  end

endmodule

// File: tb/tb_vga_raster_out.sv
// tb_vga_raster_out
//   Directed bench for vga_raster_out. The vertical timing is shortened to
//   V_VIS=12, V_FP=1, V_SYNC=2, V_BP=1 (16 lines, 25600 clk per frame) so that
//   whole frames fit in a short run. Horizontal timing keeps its defaults.
//   Expected values come from hand-computed tables and from a small timing
//   model. The model assumes that the output sampled after the (2n+4)-th clk
//   edge following reset release reflects linear raster index n.
module tb_vga_raster_out;

  localparam int HT   = 800;
  localparam int VT   = 16;
  localparam int FRM  = HT * VT;

  logic       clk;
  logic       iReset;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] color;
  logic       writeEn;
  logic       oVSync;
  logic       oBusy;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       VGA_SYNC_N;
  logic       VGA_CLK;

  int total = 0;
  int bad = 0;
  int ecnt = 0;
  int cyc = 0;
  int vs_mism = 0;

  vga_raster_out #(
    .V_VIS(12),
    .V_FP(1),
    .V_SYNC(2),
    .V_BP(1),
    .BG_COLOR(3'b001)
  ) dut (
    .clk(clk),
    .iReset(iReset),
    .x(x),
    .y(y),
    .color(color),
    .writeEn(writeEn),
    .oVSync(oVSync),
    .oBusy(oBusy),
    .VGA_R(VGA_R),
    .VGA_G(VGA_G),
    .VGA_B(VGA_B),
    .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_CLK(VGA_CLK)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (iReset) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  // Expected {R,G,B,BLANK_N,HS,VS} for line v, pixel h, with stored colour c
  function automatic logic [28:0] model(input int v, input int h, input logic [2:0] c);
    logic vis;
    logic hs;
    logic vs;
    vis = (h < 640) && (v < 12);
    hs  = !((h >= 656) && (h < 752));
    vs  = !((v >= 13) && (v < 15));
    return {(vis && c[2]) ? 8'hFF : 8'h00, (vis && c[1]) ? 8'hFF : 8'h00,
            (vis && c[0]) ? 8'hFF : 8'h00, vis, hs, vs, 2'b00};
  endfunction

  // Advance to the negedge where the output reflects raster index n
  task automatic wait_pix(input int n);
    int target;
    int g;
    target = 2 * n + 4;
    g = 0;
    while (ecnt < target && g < 200000) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (ecnt != target) begin
      bad++;
      $display("FAIL wait_pix n=%0d: at edge %0d, required %0d", n, ecnt, target);
    end
  endtask

  task automatic wait_level(input bit use_vs, input logic lvl, input int bound, output int t);
    int g;
    g = 0;
    while (((use_vs ? VGA_VS : VGA_HS) !== lvl) && g < bound) begin
      @(negedge clk);
      g++;
      if (oVSync !== VGA_VS) vs_mism++;
    end
    t = cyc;
  endtask

  task automatic wr(input logic [8:0] wx, input logic [7:0] wy, input logic [2:0] wc);
    x = wx;
    y = wy;
    color = wc;
    writeEn = 1'b1;
    @(negedge clk);
    writeEn = 1'b0;
  endtask

  task automatic test_reset(input string tag);
    logic [29:0] act;
    logic [29:0] exp;
    @(negedge clk);
    iReset = 1'b1;
    repeat (3) @(negedge clk);
    act = {VGA_R, VGA_G, VGA_B, VGA_BLANK_N, VGA_HS, VGA_VS, oVSync, VGA_SYNC_N, VGA_CLK};
    exp = {24'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s in_reset: got %h want %h", tag, act, exp);
    end
    total++;
    if (oBusy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_in_reset: got %b want 0", tag, oBusy);
    end
    iReset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      act = {VGA_R, VGA_G, VGA_B, VGA_BLANK_N, VGA_HS, VGA_VS, oVSync, VGA_SYNC_N, VGA_CLK};
      exp = {24'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, (k % 2 == 1)};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL %s post_release_%0d: got %h want %h", tag, k, act, exp);
      end
    end
  endtask

  // Row 0 back-to-back with 3'b011; rows 1..5 with 3'b001; then the
  // single-pixel and out-of-range writes.
  task automatic do_writes();
    for (int c = 0; c < 320; c++) wr(9'(c), 8'd0, 3'b011);
    for (int r = 1; r < 6; r++)
      for (int c = 0; c < 320; c++) wr(9'(c), 8'(r), 3'b001);
    wr(9'd0,   8'd1,   3'b010);
    wr(9'd320, 8'd0,   3'b111);
    wr(9'd511, 8'd0,   3'b111);
    wr(9'd400, 8'd2,   3'b111);
    wr(9'd0,   8'd240, 3'b111);
    wr(9'd5,   8'd240, 3'b111);
    wr(9'd5,   8'd3,   3'b100);
  endtask

  task automatic test_back_to_back();
    logic [28:0] act;
    logic [28:0] exp;
    for (int n = 0; n < 2 * HT; n++) begin
      wait_pix(n);
      act = {VGA_R, VGA_G, VGA_B, VGA_BLANK_N, VGA_HS, VGA_VS, 2'b00};
      exp = model(n / HT, n % HT, 3'b011);
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL row0 v=%0d h=%0d: got %h want %h", n / HT, n % HT, act, exp);
      end
    end
  endtask

  task automatic test_out_of_range();
    int pv[5] = '{2, 2, 2, 2, 2};
    int ph[5] = '{0, 1, 2, 382, 383};
    logic [2:0] pc[5] = '{3'b010, 3'b010, 3'b001, 3'b001, 3'b001};
    logic [28:0] act;
    logic [28:0] exp;
    for (int i = 0; i < 5; i++) begin
      wait_pix(pv[i] * HT + ph[i]);
      act = {VGA_R, VGA_G, VGA_B, VGA_BLANK_N, VGA_HS, VGA_VS, 2'b00};
      exp = model(pv[i], ph[i], pc[i]);
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL oor v=%0d h=%0d: got %h want %h", pv[i], ph[i], act, exp);
      end
    end
  endtask

  task automatic test_pixel_write();
    int pv[9] = '{6, 6, 6, 6, 6, 7, 7, 7, 7};
    int ph[9] = '{9, 10, 11, 12, 160, 9, 10, 11, 12};
    logic [2:0] pc[9] = '{3'b001, 3'b100, 3'b100, 3'b001, 3'b001,
                          3'b001, 3'b100, 3'b100, 3'b001};
    logic [28:0] act;
    logic [28:0] exp;
    for (int i = 0; i < 9; i++) begin
      wait_pix(pv[i] * HT + ph[i]);
      act = {VGA_R, VGA_G, VGA_B, VGA_BLANK_N, VGA_HS, VGA_VS, 2'b00};
      exp = model(pv[i], ph[i], pc[i]);
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL pix v=%0d h=%0d: got %h want %h", pv[i], ph[i], act, exp);
      end
    end
  endtask

  task automatic test_blanking();
    int pv[4] = '{11, 11, 12, 12};
    int ph[4] = '{639, 640, 100, 700};
    logic [28:0] act;
    logic [28:0] exp;
    for (int i = 0; i < 4; i++) begin
      wait_pix(pv[i] * HT + ph[i]);
      act = {VGA_R, VGA_G, VGA_B, VGA_BLANK_N, VGA_HS, VGA_VS, 2'b00};
      exp = model(pv[i], ph[i], 3'b001);
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL blank v=%0d h=%0d: got %h want %h", pv[i], ph[i], act, exp);
      end
    end
  endtask

  task automatic test_sync();
    int t0;
    int t1;
    int t2;
    vs_mism = 0;
    wait_level(1'b1, 1'b1, 60000, t0);
    wait_level(1'b1, 1'b0, 60000, t0);
    wait_level(1'b1, 1'b1, 60000, t1);
    wait_level(1'b1, 1'b0, 60000, t2);
    total++;
    if (t1 - t0 != 3200) begin
      bad++;
      $display("FAIL vs_low: got %0d clk want 3200", t1 - t0);
    end
    total++;
    if (t2 - t0 != 2 * FRM) begin
      bad++;
      $display("FAIL vs_period: got %0d clk want %0d", t2 - t0, 2 * FRM);
    end
    wait_level(1'b0, 1'b1, 4000, t0);
    wait_level(1'b0, 1'b0, 4000, t0);
    wait_level(1'b0, 1'b1, 4000, t1);
    wait_level(1'b0, 1'b0, 4000, t2);
    total++;
    if (t1 - t0 != 192) begin
      bad++;
      $display("FAIL hs_low: got %0d clk want 192", t1 - t0);
    end
    total++;
    if (t2 - t0 != 1600) begin
      bad++;
      $display("FAIL hs_period: got %0d clk want 1600", t2 - t0);
    end
    total++;
    if (vs_mism != 0) begin
      bad++;
      $display("FAIL ovsync_copy: got %0d differing clk want 0", vs_mism);
    end
  endtask

`ifdef FB_CLEAR_EN
  task automatic test_clear();
    int cnt;
    int g;
    int base;
    int pv[4] = '{0, 6, 6, 7};
    int ph[4] = '{0, 10, 11, 12};
    logic [28:0] act;
    logic [28:0] exp;
    @(negedge clk);
    iReset = 1'b1;
    repeat (2) @(negedge clk);
    iReset = 1'b0;
    cnt = 0;
    g = 0;
    while (cnt < 40000 && g < 50000) begin
      @(negedge clk);
      g++;
      if (oBusy === 1'b1) cnt++;
      x = 9'd5; y = 8'd3; color = 3'b100;
      writeEn = (cnt == 100);
    end
    writeEn = 1'b0;
    iReset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (oBusy !== 1'b0) begin
      bad++;
      $display("FAIL clr_reset_busy: got %b want 0", oBusy);
    end
    iReset = 1'b0;
    cnt = 0;
    g = 0;
    while (g < 90000) begin
      @(negedge clk);
      g++;
      if (oBusy === 1'b1) cnt++;
      else if (cnt > 0) break;
      x = 9'd5; y = 8'd3; color = 3'b100;
      writeEn = (cnt == 100);
    end
    writeEn = 1'b0;
    total++;
    if (cnt != 76800) begin
      bad++;
      $display("FAIL clr_busy_len: got %0d clk want 76800", cnt);
    end
    base = (ecnt / (2 * FRM) + 1) * FRM;
    for (int i = 0; i < 4; i++) begin
      wait_pix(base + pv[i] * HT + ph[i]);
      act = {VGA_R, VGA_G, VGA_B, VGA_BLANK_N, VGA_HS, VGA_VS, 2'b00};
      exp = model(pv[i], ph[i], 3'b001);
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL clr_pix v=%0d h=%0d: got %h want %h", pv[i], ph[i], act, exp);
      end
    end
  endtask
`endif

  initial begin
    iReset = 1'b1;
    writeEn = 1'b0;
    x = '0;
    y = '0;
    color = '0;
    test_reset("power_on");
`ifdef FB_CLEAR_EN
    test_clear();
`else
    do_writes();
    test_reset("mid_frame");
    test_back_to_back();
    test_out_of_range();
    test_pixel_write();
    test_blanking();
    test_sync();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
